vdp_cpu_port: RTL

CPU-side port interface of the TMS9918-compatible VDP: decodes Z80 accesses to the data port (0x98) and control port (0x99), maintains the two-byte address/register latch, the 14-bit auto-incrementing VRAM pointer, the read-ahead buffer, the eight write-only VDP registers and the status register. It sits between the tv80n bus decode in the top level and the `video` block. It issues single VRAM read/write requests to the video block's memory arbiter and exports register contents plus the interrupt line.

---
 rtl/vdp_cpu_port_if.sv | 22 ++
 rtl/vdp_cpu_port.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port_if.sv
// VRAM request/grant handshake between the VDP CPU port and the video block's memory arbiter.
// The port raises a single request and holds it until the arbiter returns a one-cycle ack.
interface vdp_cpu_port_if #(
  parameter int ADDR_BITS = 14
);
  logic                 vram_req;
  logic                 vram_we;
  logic [ADDR_BITS-1:0] vram_addr;
  logic [7:0]           vram_wdata;
  logic                 vram_ack;
  logic [7:0]           vram_rdata;

  modport master (
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_ack, vram_rdata
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port: data/control port decode, address latch, auto-incrementing VRAM
// pointer, read-ahead buffer, write-only registers, status flags and interrupt line.
module vdp_cpu_port #(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_ena,
  input  logic        sel_data,
  input  logic        sel_ctrl,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  vdp_cpu_port_if.master vram,
  input  logic        frame_pulse,
  input  logic        coinc_pulse,
  input  logic        fifth_pulse,
  input  logic [4:0]  fifth_num,
  output logic [63:0] regs,
  output logic        overrun,
  output logic        n_int
);

  typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_t;

  bus_state_t           bus_state, bus_next;
  logic                 acc_start, acc_end;
  logic                 acc_data, acc_read;
  logic                 bus_active;

  logic [7:0]           regs_r [8];
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           rbuf;
  logic [7:0]           latch;
  logic                 second;

  logic                 flag_f, flag_c, flag_s5;
  logic [4:0]           num;

  logic                 ctrl_wr, data_wr, data_rd_end, stat_rd_end;
  logic                 ptr_load, reg_load, ack_hit, s5_kept;
  logic [ADDR_BITS-1:0] ptr_seq, ptr_load_val;
  logic                 new_req, new_we;
  logic [ADDR_BITS-1:0] new_addr;

  assign bus_active = (sel_data | sel_ctrl) & (~rd_n | ~wr_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_state <= BUS_IDLE;
      acc_data  <= 1'b0;
      acc_read  <= 1'b0;
    end else begin
      bus_state <= bus_next;
      if (acc_start) begin
        acc_data <= sel_data;
        acc_read <= ~rd_n;
      end
    end
  end

  // One start and one end per Z80 bus cycle, however many wait states stretch it.
  always_comb begin
    bus_next  = bus_state;
    acc_start = 1'b0;
    acc_end   = 1'b0;
    if (clk_ena) begin
      case (bus_state)
        BUS_IDLE: if (bus_active) begin
          bus_next  = BUS_BUSY;
          acc_start = 1'b1;
        end
        BUS_BUSY: if (!bus_active) begin
          bus_next = BUS_IDLE;
          acc_end  = 1'b1;
        end
        default: bus_next = BUS_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_wr      = acc_start & sel_ctrl & ~wr_n;
    data_wr      = acc_start & sel_data & ~wr_n;
    data_rd_end  = acc_end & acc_data & acc_read;
    stat_rd_end  = acc_end & ~acc_data & acc_read;
    ptr_load     = ctrl_wr & second & ~din[7];
    reg_load     = ctrl_wr & second & din[7];
    ack_hit      = vram.vram_ack & vram.vram_req;
    ptr_seq      = ack_hit ? ptr + ADDR_BITS'(1) : ptr;
    ptr_load_val = ADDR_BITS'({din[5:0], latch});
    // A request landing on an ack cycle targets the pointer as it stands after that ack.
    new_req  = 1'b0;
    new_we   = 1'b0;
    new_addr = ptr_seq;
    if (ptr_load && !din[6]) begin
      new_req  = 1'b1;
      new_addr = ptr_load_val;
    end
    if (data_wr) begin
      new_req = 1'b1;
      new_we  = 1'b1;
    end
    if (data_rd_end) new_req = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs_r[i] <= 8'h00;
      ptr    <= '0;
      rbuf   <= 8'h00;
      latch  <= 8'h00;
      second <= 1'b0;
    end else begin
      ptr <= ptr_load ? ptr_load_val : ptr_seq;
      if (ctrl_wr) begin
        second <= ~second;
        if (!second) latch <= din;
      end else if (data_wr || data_rd_end || stat_rd_end) begin
        second <= 1'b0;
      end
      if (reg_load) regs_r[din[2:0]] <= latch;
      if (data_wr) rbuf <= din;
      else if (ack_hit && !vram.vram_we) rbuf <= vram.vram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram.vram_req   <= 1'b0;
      vram.vram_we    <= 1'b0;
      vram.vram_addr  <= '0;
      vram.vram_wdata <= 8'h00;
      overrun         <= 1'b0;
    end else begin
      overrun <= new_req & vram.vram_req & ~vram.vram_ack;
      if (new_req) begin
        vram.vram_req  <= 1'b1;
        vram.vram_we   <= new_we;
        vram.vram_addr <= new_addr;
        if (data_wr) vram.vram_wdata <= din;
      end else if (ack_hit) begin
        vram.vram_req <= 1'b0;
      end
    end
  end

  assign s5_kept = flag_s5 & ~stat_rd_end;

  // Event sets are applied after the status-read clear so a coincident event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_f  <= 1'b0;
      flag_c  <= 1'b0;
      flag_s5 <= 1'b0;
      num     <= 5'd0;
    end else begin
      flag_f <= frame_pulse | (flag_f & ~stat_rd_end);
      flag_c <= coinc_pulse | (flag_c & ~stat_rd_end);
      if (fifth_pulse && !s5_kept) begin
        flag_s5 <= 1'b1;
        num     <= fifth_num;
      end else begin
        flag_s5 <= s5_kept;
      end
    end
  end

  assign dout  = sel_ctrl ? {flag_f, flag_s5, flag_c, (flag_s5 ? num : 5'h1F)} : rbuf;
  assign regs  = {regs_r[7], regs_r[6], regs_r[5], regs_r[4],
                  regs_r[3], regs_r[2], regs_r[1], regs_r[0]};
  assign n_int = ~(flag_f & regs_r[1][5]);

endmodule
